// File: rtl/dot_prod_accum_pkg.sv
// Shared widths and output-state encoding for the dot-product pipeline.
// Also used by dot_prod_pip.
package dot_prod_accum_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Sum width that holds LENGTH full-scale products without overflow.
    function automatic int sum_bits(input int in_bits, input int length);
        return in_bits + clog2(length);
    endfunction

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/dot_prod_accum_lane.sv
// One signed accumulator plus its window output register; no added latency.
// No flow control of its own: the parent only pulses the enables on accepted samples.
module dot_prod_accum_lane
    import dot_prod_accum_pkg::*;
#(
    parameter int IN_BITS  = 16,
    parameter int SUM_BITS = 21
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_BITS-1:0]  dat_i,
    input  logic                acc_en_i,
    input  logic                final_en_i,
    input  logic                clr_i,
    output logic [SUM_BITS-1:0] sum_o
);

    logic [SUM_BITS-1:0] acc_q, acc_d;
    logic [SUM_BITS-1:0] sum_q, sum_d;
    logic [SUM_BITS-1:0] ext_dat;

    assign ext_dat = {{(SUM_BITS-IN_BITS){dat_i[IN_BITS-1]}}, dat_i};

    always_comb begin
        acc_d = acc_q;
        sum_d = sum_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (final_en_i) begin
            sum_d = acc_q + ext_dat;
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = acc_q + ext_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/dot_prod_accum.sv
// Sums LENGTH complex products per window; sum valid the cycle after the last sample.
// Stalls input only on a window's final sample while the previous sum is still unaccepted.
module dot_prod_accum
    import dot_prod_accum_pkg::*;
#(
    parameter int I_BITS     = 16,
    parameter int Q_BITS     = 16,
    parameter int LENGTH     = 32,
    parameter int SUM_I_BITS = sum_bits(I_BITS, LENGTH),
    parameter int SUM_Q_BITS = sum_bits(Q_BITS, LENGTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_axis_product_tvalid,
    output logic                  s_axis_product_tready,
    input  logic [I_BITS-1:0]     product_i,
    input  logic [Q_BITS-1:0]     product_q,
    input  logic                  clear,
    output logic                  m_axis_sum_tvalid,
    input  logic                  m_axis_sum_tready,
    output logic [SUM_I_BITS-1:0] sum_i,
    output logic [SUM_Q_BITS-1:0] sum_q,
    output logic [15:0]           window_count
);

    localparam int                  CNT_BITS = clog2(LENGTH);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(LENGTH - 1);

    out_state_e          state_q;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic [15:0]         wcnt_q, wcnt_d;

    logic is_last;
    logic in_hs;
    logic take;
    logic last_take;
    logic out_hs;

    assign is_last   = (count_q == CNT_LAST);
    assign m_axis_sum_tvalid = (state_q == OUT_FULL);

    // Only the closing sample needs the output register, so only it waits.
    assign s_axis_product_tready = !reset &&
                                   !(is_last && m_axis_sum_tvalid && !m_axis_sum_tready);

    assign in_hs     = s_axis_product_tvalid && s_axis_product_tready;
    assign take      = in_hs && !clear;
    assign last_take = take && is_last;
    assign out_hs    = m_axis_sum_tvalid && m_axis_sum_tready;

    always_comb begin
        count_d = count_q;
        wcnt_d  = wcnt_q;
        if (clear) begin
            count_d = '0;
        end else if (take) begin
            count_d = is_last ? '0 : count_q + CNT_BITS'(1);
        end
        if (out_hs) begin
            wcnt_d = wcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OUT_EMPTY;
            count_q <= '0;
            wcnt_q  <= '0;
        end else begin
            count_q <= count_d;
            wcnt_q  <= wcnt_d;
            case (state_q)
                OUT_EMPTY: if (last_take)            state_q <= OUT_FULL;
                OUT_FULL:  if (out_hs && !last_take) state_q <= OUT_EMPTY;
                default:                             state_q <= OUT_EMPTY;
            endcase
        end
    end

    assign window_count = wcnt_q;

    dot_prod_accum_lane #(
        .IN_BITS  (I_BITS),
        .SUM_BITS (SUM_I_BITS)
    ) u_lane_i (
        .clk        (clk),
        .reset      (reset),
        .dat_i      (product_i),
        .acc_en_i   (take && !is_last),
        .final_en_i (last_take),
        .clr_i      (clear),
        .sum_o      (sum_i)
    );

    dot_prod_accum_lane #(
        .IN_BITS  (Q_BITS),
        .SUM_BITS (SUM_Q_BITS)
    ) u_lane_q (
        .clk        (clk),
        .reset      (reset),
        .dat_i      (product_q),
        .acc_en_i   (take && !is_last),
        .final_en_i (last_take),
        .clr_i      (clear),
        .sum_o      (sum_q)
    );

endmodule

// File: tb/tb_dot_prod_accum.sv
// Bench for dot_prod_accum with LENGTH=4, 16-bit products, 18-bit sums.
module tb_dot_prod_accum;

    localparam int LEN = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               s_vld = 1'b0;
    logic               clr = 1'b0;
    logic               m_rdy = 1'b0;
    logic signed [15:0] pi = '0;
    logic signed [15:0] pq = '0;
    logic               s_rdy;
    logic               m_vld;
    logic [17:0]        sum_i;
    logic [17:0]        sum_q;
    logic [15:0]        wc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dot_prod_accum #(
        .I_BITS (16),
        .Q_BITS (16),
        .LENGTH (LEN)
    ) dut (
        .clk                   (clk),
        .reset                 (rst),
        .s_axis_product_tvalid (s_vld),
        .s_axis_product_tready (s_rdy),
        .product_i             (pi),
        .product_q             (pq),
        .clear                 (clr),
        .m_axis_sum_tvalid     (m_vld),
        .m_axis_sum_tready     (m_rdy),
        .sum_i                 (sum_i),
        .sum_q                 (sum_q),
        .window_count          (wc)
    );

    // Reference: accepted products collect in a queue; a full queue becomes one sum.
    int win_i[$];
    int win_q[$];
    bit mdl_full = 1'b0;
    int mdl_i = 0;
    int mdl_q = 0;
    int mdl_wc = 0;

    function automatic bit mdl_rdy();
        return !rst && !(win_i.size() == LEN - 1 && mdl_full && !m_rdy);
    endfunction

    always @(posedge clk) begin : model
        bit take;
        bit ohs;
        int si;
        int sq;
        if (rst) begin
            win_i.delete();
            win_q.delete();
            mdl_full = 1'b0;
            mdl_i = 0;
            mdl_q = 0;
            mdl_wc = 0;
        end else begin
            take = s_vld && mdl_rdy();
            ohs  = mdl_full && m_rdy;
            if (ohs) begin
                mdl_wc   = (mdl_wc + 1) % 65536;
                mdl_full = 1'b0;
            end
            if (clr) begin
                win_i.delete();
                win_q.delete();
            end else if (take) begin
                win_i.push_back(int'(pi));
                win_q.push_back(int'(pq));
                if (win_i.size() == LEN) begin
                    si = 0;
                    sq = 0;
                    foreach (win_i[k]) si += win_i[k];
                    foreach (win_q[k]) sq += win_q[k];
                    mdl_i = si;
                    mdl_q = sq;
                    mdl_full = 1'b1;
                    win_i.delete();
                    win_q.delete();
                end
            end
        end
    end

    task automatic drive(input logic v, input logic signed [15:0] a, input logic signed [15:0] b,
                         input logic c);
        s_vld = v;
        pi    = a;
        pq    = b;
        clr   = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_rdy = 1'b1;
        drive(1'b1, 16'sd5, 16'sd6, 1'b0);
        repeat (2) tick();
        @(negedge clk);
        n_cmp++; if (s_rdy !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b want 0", s_rdy); end
        n_cmp++; if (m_vld !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b want 0", m_vld); end
        n_cmp++; if (sum_i !== 18'd0 || sum_q !== 18'd0) begin n_err++; $display("FAIL rst_sum: got %0d,%0d want 0,0", sum_i, sum_q); end
        n_cmp++; if (wc !== 16'd0) begin n_err++; $display("FAIL rst_wc: got %0d want 0", wc); end
        tick();
        rst = 1'b0;
        drive(1'b0, 16'sd0, 16'sd0, 1'b0);
    endtask

    task automatic test_basic();
        m_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 16'(k), 16'(-k), 1'b0);
            @(negedge clk);
            n_cmp++; if (s_rdy !== 1'b1) begin n_err++; $display("FAIL basic_tready k=%0d: got %b want 1", k, s_rdy); end
            tick();
        end
        drive(1'b0, 16'sd0, 16'sd0, 1'b0);
        @(negedge clk);
        n_cmp++; if (m_vld !== 1'b1) begin n_err++; $display("FAIL basic_tvalid: got %b want 1", m_vld); end
        n_cmp++; if (int'($signed(sum_i)) !== 10 || int'($signed(sum_q)) !== -10) begin
            n_err++; $display("FAIL basic_sum: got %0d,%0d want 10,-10", $signed(sum_i), $signed(sum_q)); end
        tick();
        @(negedge clk);
        n_cmp++; if (m_vld !== 1'b0) begin n_err++; $display("FAIL basic_oneshot: got %b want 0", m_vld); end
        n_cmp++; if (wc !== 16'd1) begin n_err++; $display("FAIL basic_wc: got %0d want 1", wc); end
        tick();
    endtask

    task automatic test_no_overflow();
        m_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 16'sh8000, 16'sh7FFF, 1'b0);
            @(negedge clk);
            if (k == 4) begin
                n_cmp++; if (m_vld !== 1'b1 || int'($signed(sum_i)) !== -131072 || int'($signed(sum_q)) !== 131068) begin
                    n_err++; $display("FAIL ovf_sum1: got v=%b %0d,%0d want 1 -131072,131068", m_vld, $signed(sum_i), $signed(sum_q)); end
            end
            tick();
        end
        drive(1'b0, 16'sd0, 16'sd0, 1'b0);
        @(negedge clk);
        n_cmp++; if (m_vld !== 1'b1 || int'($signed(sum_i)) !== -131072 || int'($signed(sum_q)) !== 131068) begin
            n_err++; $display("FAIL ovf_sum2: got v=%b %0d,%0d want 1 -131072,131068", m_vld, $signed(sum_i), $signed(sum_q)); end
        tick();
        @(negedge clk);
        n_cmp++; if (wc !== 16'd3) begin n_err++; $display("FAIL ovf_wc: got %0d want 3", wc); end
        tick();
    endtask

    task automatic test_backpressure();
        logic signed [15:0] ai[9];
        logic signed [15:0] aq[9];
        int w1i, w1q, w2i, w2q;
        w1i = 0; w1q = 0; w2i = 0; w2q = 0;
        for (int k = 0; k < 9; k++) begin
            ai[k] = 16'($urandom);
            aq[k] = 16'($urandom);
            if (k < 4) begin w1i += int'(ai[k]); w1q += int'(aq[k]); end
            else if (k < 8) begin w2i += int'(ai[k]); w2q += int'(aq[k]); end
        end
        m_rdy = 1'b0;
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, ai[k], aq[k], 1'b0);
            @(negedge clk);
            n_cmp++; if (s_rdy !== 1'b1) begin n_err++; $display("FAIL bp_tready k=%0d: got %b want 1", k, s_rdy); end
            tick();
        end
        drive(1'b1, ai[7], aq[7], 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (s_rdy !== 1'b0) begin n_err++; $display("FAIL bp_stall c=%0d: got %b want 0", c, s_rdy); end
            n_cmp++; if (m_vld !== 1'b1 || int'($signed(sum_i)) !== w1i || int'($signed(sum_q)) !== w1q) begin
                n_err++; $display("FAIL bp_hold c=%0d: got v=%b %0d,%0d want 1 %0d,%0d", c, m_vld, $signed(sum_i), $signed(sum_q), w1i, w1q); end
            tick();
        end
        m_rdy = 1'b1;
        @(negedge clk);
        n_cmp++; if (s_rdy !== 1'b1) begin n_err++; $display("FAIL bp_passthru: got %b want 1", s_rdy); end
        tick();
        m_rdy = 1'b0;
        drive(1'b1, ai[8], aq[8], 1'b0);
        @(negedge clk);
        n_cmp++; if (m_vld !== 1'b1 || int'($signed(sum_i)) !== w2i || int'($signed(sum_q)) !== w2q) begin
            n_err++; $display("FAIL bp_sum2: got v=%b %0d,%0d want 1 %0d,%0d", m_vld, $signed(sum_i), $signed(sum_q), w2i, w2q); end
        n_cmp++; if (wc !== 16'd4) begin n_err++; $display("FAIL bp_wc1: got %0d want 4", wc); end
        tick();
        drive(1'b0, 16'sd0, 16'sd0, 1'b0);
        m_rdy = 1'b1;
        tick();
        drive(1'b0, 16'sd0, 16'sd0, 1'b1);
        @(negedge clk);
        n_cmp++; if (wc !== 16'd5 || m_vld !== 1'b0) begin n_err++; $display("FAIL bp_drain: got wc=%0d v=%b want 5 0", wc, m_vld); end
        tick();
        clr = 1'b0;
    endtask

    task automatic test_toggle();
        int ei, eq;
        logic signed [15:0] a, b;
        ei = 0; eq = 0;
        m_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            drive((k % 2) == 0, a, b, 1'b0);
            if ((k % 2) == 0) begin ei += int'(a); eq += int'(b); end
            @(negedge clk);
            if (k == 7) begin
                n_cmp++; if (m_vld !== 1'b1 || int'($signed(sum_i)) !== ei || int'($signed(sum_q)) !== eq) begin
                    n_err++; $display("FAIL toggle_sum: got v=%b %0d,%0d want 1 %0d,%0d", m_vld, $signed(sum_i), $signed(sum_q), ei, eq); end
            end
            tick();
        end
        drive(1'b0, 16'sd0, 16'sd0, 1'b0);
    endtask

    task automatic test_clear();
        int ei, eq;
        logic signed [15:0] a, b;
        ei = 0; eq = 0;
        m_rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'b0);
            tick();
        end
        drive(1'b1, 16'sh1234, 16'sh4321, 1'b1);
        @(negedge clk);
        n_cmp++; if (s_rdy !== 1'b1) begin n_err++; $display("FAIL clr_tready: got %b want 1", s_rdy); end
        tick();
        for (int k = 0; k < 4; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            ei += int'(a); eq += int'(b);
            drive(1'b1, a, b, 1'b0);
            tick();
        end
        drive(1'b0, 16'sd0, 16'sd0, 1'b0);
        @(negedge clk);
        n_cmp++; if (m_vld !== 1'b1 || int'($signed(sum_i)) !== ei || int'($signed(sum_q)) !== eq) begin
            n_err++; $display("FAIL clr_sum: got v=%b %0d,%0d want 1 %0d,%0d", m_vld, $signed(sum_i), $signed(sum_q), ei, eq); end
        n_cmp++; if (wc !== 16'd6) begin n_err++; $display("FAIL clr_wc: got %0d want 6", wc); end
        tick();
    endtask

    task automatic test_reset_mid();
        int ei, eq;
        logic signed [15:0] a, b;
        ei = 0; eq = 0;
        m_rdy = 1'b0;
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'b0);
            tick();
        end
        m_rdy = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (s_rdy !== 1'b0) begin n_err++; $display("FAIL rstm_tready: got %b want 0", s_rdy); end
        tick();
        rst = 1'b0;
        drive(1'b0, 16'sd0, 16'sd0, 1'b0);
        @(negedge clk);
        n_cmp++; if (m_vld !== 1'b0 || sum_i !== 18'd0 || sum_q !== 18'd0 || wc !== 16'd0) begin
            n_err++; $display("FAIL rstm_clear: got v=%b %0d,%0d wc=%0d want 0 0,0 0", m_vld, sum_i, sum_q, wc); end
        tick();
        for (int k = 0; k < 4; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            ei += int'(a); eq += int'(b);
            drive(1'b1, a, b, 1'b0);
            tick();
        end
        drive(1'b0, 16'sd0, 16'sd0, 1'b0);
        @(negedge clk);
        n_cmp++; if (m_vld !== 1'b1 || int'($signed(sum_i)) !== ei || int'($signed(sum_q)) !== eq) begin
            n_err++; $display("FAIL rstm_sum: got v=%b %0d,%0d want 1 %0d,%0d", m_vld, $signed(sum_i), $signed(sum_q), ei, eq); end
        tick();
        @(negedge clk);
        n_cmp++; if (wc !== 16'd1) begin n_err++; $display("FAIL rstm_wc: got %0d want 1", wc); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), $urandom_range(0, 15) == 0);
            m_rdy = $urandom_range(0, 2) != 0;
            @(negedge clk);
            n_cmp++; if (s_rdy !== mdl_rdy()) begin n_err++; $display("FAIL rnd_tready c=%0d: got %b want %b", c, s_rdy, mdl_rdy()); end
            n_cmp++; if (m_vld !== mdl_full) begin n_err++; $display("FAIL rnd_tvalid c=%0d: got %b want %b", c, m_vld, mdl_full); end
            if (mdl_full) begin
                n_cmp++; if (int'($signed(sum_i)) !== mdl_i || int'($signed(sum_q)) !== mdl_q) begin
                    n_err++; $display("FAIL rnd_sum c=%0d: got %0d,%0d want %0d,%0d", c, $signed(sum_i), $signed(sum_q), mdl_i, mdl_q); end
            end
            n_cmp++; if (wc !== 16'(mdl_wc)) begin n_err++; $display("FAIL rnd_wc c=%0d: got %0d want %0d", c, wc, mdl_wc); end
            tick();
        end
        drive(1'b0, 16'sd0, 16'sd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_overflow();
        test_backpressure();
        test_toggle();
        test_clear();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
